// File: rtl/ddr_cmd_decoder_pkg.sv
// ---------------------------------------------------------------------------
// ddr_cmd_decoder_pkg
// Shared types and constants for the DDR4 command/address receiver:
//   - cmd_enc_t    : decoded command code presented on cmd_code
//   - bank_state_t : per-bank FSM state used by the bank tracker
//   - address field widths, bank count, default CL/CWL
//   - parity_odd() : reduction helper for the optional CA parity check
//                    (compiled in only when DDR_CMD_PARITY_EN is defined)
// ---------------------------------------------------------------------------
package ddr_cmd_decoder_pkg;

  localparam int BG_WIDTH    = 2;
  localparam int BA_WIDTH    = 2;
  localparam int ROW_WIDTH   = 15;
  localparam int COL_WIDTH   = 10;
  localparam int BANK_IDX_W  = BG_WIDTH + BA_WIDTH;
  localparam int NUM_BANKS   = 1 << BANK_IDX_W;

  localparam int CL_DEFAULT  = 11;
  localparam int CWL_DEFAULT = 9;

  // act_n, ras/cas/we, addr17/13/12/11/10, addr9_0, bg, ba, PAR
  localparam int PAR_VEC_W   = 1 + 3 + 5 + 10 + BG_WIDTH + BA_WIDTH + 1;

  typedef enum logic [3:0] {
    DES   = 4'd0,
    NOP   = 4'd1,
    ACT   = 4'd2,
    PRE   = 4'd3,
    PREA  = 4'd4,
    CAS_R = 4'd5,
    CAS_W = 4'd6,
    MRS   = 4'd7,
    REF   = 4'd8,
    ZQCL  = 4'd9,
    RSVD  = 4'd10
  } cmd_enc_t;

  typedef enum logic {
    BANK_IDLE   = 1'b0,
    BANK_ACTIVE = 1'b1
  } bank_state_t;

  // Returns 1 when the vector has an odd number of ones (even parity broken).
  function automatic logic parity_odd(input logic [PAR_VEC_W-1:0] vec);
    return ^vec;
  endfunction

endpackage

// File: rtl/ddr_cmd_decoder_if.sv
// ---------------------------------------------------------------------------
// ddr_cmd_decoder_if
// Bundles the DDR4 command/address pins and the decoder's result outputs.
//   master : controller / test side (drives pins, observes results)
//   slave  : ddr_cmd_decoder (samples pins, drives results)
// Pins   : cke, cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14, bc_n_a12, ap_a10,
//          addr17, addr13, addr11, addr9_0[9:0], bg_addr, ba_addr, PAR
// Results: cmd_valid, cmd_code, cmd_bg, cmd_ba, cmd_row, cmd_col, illegal,
//          bank_open, rd_launch, wr_capture, parity_err
// ---------------------------------------------------------------------------
interface ddr_cmd_decoder_if import ddr_cmd_decoder_pkg::*; ;

  logic                  cke;
  logic                  cs_n;
  logic                  act_n;
  logic                  ras_n_a16;
  logic                  cas_n_a15;
  logic                  we_n_a14;
  logic                  bc_n_a12;
  logic                  ap_a10;
  logic                  addr17;
  logic                  addr13;
  logic                  addr11;
  logic [9:0]            addr9_0;
  logic [BG_WIDTH-1:0]   bg_addr;
  logic [BA_WIDTH-1:0]   ba_addr;
  logic                  PAR;

  logic                  cmd_valid;
  cmd_enc_t              cmd_code;
  logic [BG_WIDTH-1:0]   cmd_bg;
  logic [BA_WIDTH-1:0]   cmd_ba;
  logic [ROW_WIDTH-1:0]  cmd_row;
  logic [COL_WIDTH-1:0]  cmd_col;
  logic                  illegal;
  logic [NUM_BANKS-1:0]  bank_open;
  logic                  rd_launch;
  logic                  wr_capture;
  logic                  parity_err;

  modport master (
    output cke, cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14, bc_n_a12, ap_a10,
           addr17, addr13, addr11, addr9_0, bg_addr, ba_addr, PAR,
    input  cmd_valid, cmd_code, cmd_bg, cmd_ba, cmd_row, cmd_col, illegal,
           bank_open, rd_launch, wr_capture, parity_err
  );

  modport slave (
    input  cke, cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14, bc_n_a12, ap_a10,
           addr17, addr13, addr11, addr9_0, bg_addr, ba_addr, PAR,
    output cmd_valid, cmd_code, cmd_bg, cmd_ba, cmd_row, cmd_col, illegal,
           bank_open, rd_launch, wr_capture, parity_err
  );

endinterface

// File: rtl/ddr_bank_tracker.sv
// ---------------------------------------------------------------------------
// ddr_bank_tracker
// Per-bank IDLE/ACTIVE state, open-row storage and command legality.
// Ports:
//   clock_t, reset_n : clock, async active-low reset
//   run_i            : 0 clears all state synchronously (reset release window)
//   cmd_go_i         : a decoded command (not DES/NOP, no parity error)
//   cmd_code_i, bg_i, ba_i, row_i : decoded command and its fields
//   illegal_o        : combinational legality verdict for the current command
//   bank_open_o      : registered per-bank ACTIVE flags, index {bg, ba}
//   open_row_o       : row latched by the last legal ACT to each bank
// ---------------------------------------------------------------------------
module ddr_bank_tracker import ddr_cmd_decoder_pkg::*; (
  input  logic                                 clock_t,
  input  logic                                 reset_n,
  input  logic                                 run_i,
  input  logic                                 cmd_go_i,
  input  cmd_enc_t                             cmd_code_i,
  input  logic [BG_WIDTH-1:0]                  bg_i,
  input  logic [BA_WIDTH-1:0]                  ba_i,
  input  logic [ROW_WIDTH-1:0]                 row_i,
  output logic                                 illegal_o,
  output logic [NUM_BANKS-1:0]                 bank_open_o,
  output logic [NUM_BANKS-1:0][ROW_WIDTH-1:0]  open_row_o
);

  bank_state_t                        bank_q [NUM_BANKS];
  bank_state_t                        bank_d [NUM_BANKS];
  logic [NUM_BANKS-1:0][ROW_WIDTH-1:0] row_q;
  logic [NUM_BANKS-1:0][ROW_WIDTH-1:0] row_d;
  logic [BANK_IDX_W-1:0]              idx_s;
  logic                               any_active_s;
  logic                               tgt_active_s;
  logic                               illegal_s;

  // Legality of the command presented this cycle against current bank state.
  always_comb begin
    idx_s        = {bg_i, ba_i};
    any_active_s = 1'b0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      any_active_s = any_active_s | (bank_q[i] == BANK_ACTIVE);
    end
    tgt_active_s = (bank_q[idx_s] == BANK_ACTIVE);
    illegal_s    = 1'b0;
    case (cmd_code_i)
      ACT:            illegal_s = tgt_active_s;
      CAS_R, CAS_W:   illegal_s = !tgt_active_s;
      MRS, REF, ZQCL: illegal_s = any_active_s;
      RSVD:           illegal_s = 1'b1;
      default:        illegal_s = 1'b0;
    endcase
    illegal_s = illegal_s & cmd_go_i;
  end

  // Bank FSM next state; illegal commands leave everything untouched.
  always_comb begin
    bank_d = bank_q;
    row_d  = row_q;
    if (!run_i) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        bank_d[i] = BANK_IDLE;
      end
      row_d = '0;
    end else if (cmd_go_i && !illegal_s) begin
      case (cmd_code_i)
        ACT: begin
          bank_d[idx_s] = BANK_ACTIVE;
          row_d[idx_s]  = row_i;
        end
        PRE: bank_d[idx_s] = BANK_IDLE;
        PREA: begin
          for (int i = 0; i < NUM_BANKS; i++) begin
            bank_d[i] = BANK_IDLE;
          end
        end
        default: begin
          bank_d = bank_q;
        end
      endcase
    end else begin
      bank_d = bank_q;
    end
  end

  // Bank state and open-row registers.
  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        bank_q[i] <= BANK_IDLE;
      end
      row_q <= '0;
    end else begin
      bank_q <= bank_d;
      row_q  <= row_d;
    end
  end

  // Flatten bank FSM states to the open-flag vector.
  always_comb begin
    bank_open_o = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      bank_open_o[i] = (bank_q[i] == BANK_ACTIVE);
    end
  end

  assign illegal_o  = illegal_s;
  assign open_row_o = row_q;

endmodule

// File: rtl/ddr_cmd_decoder.sv
// ---------------------------------------------------------------------------
// ddr_cmd_decoder
// Memory-side DDR4 command/address receiver. Samples the CA pins on each
// rising clock_t, decodes command + fields (1-cycle registered latency),
// tracks bank state via ddr_bank_tracker, flags illegal commands and emits
// rd_launch / wr_capture pulses CL / CWL clocks after a legal CAS.
// Ports:
//   clock_t : memory clock
//   reset_n : async assert, released through a 2-flop synchronizer
//   bus     : ddr_cmd_decoder_if.slave (CA pins in, decode results out)
// Parameters: CL, CWL (both must be >= 2)
// Optional: define DDR_CMD_PARITY_EN to enable even CA parity checking;
//           otherwise PAR is ignored and parity_err stays 0.
// ---------------------------------------------------------------------------
module ddr_cmd_decoder import ddr_cmd_decoder_pkg::*; #(
  parameter int CL  = CL_DEFAULT,
  parameter int CWL = CWL_DEFAULT
) (
  input  logic             clock_t,
  input  logic             reset_n,
  ddr_cmd_decoder_if.slave bus
);

  logic [1:0]                          rst_sync_q, rst_sync_d;
  logic                                run_s;
  cmd_enc_t                            dec_code_s;
  cmd_enc_t                            code_s;
  logic [ROW_WIDTH-1:0]                row_s;
  logic                                par_err_s;
  logic                                go_s;
  logic                                illegal_s;
  logic [NUM_BANKS-1:0][ROW_WIDTH-1:0] open_row_s;
  logic                                unused_s;

  logic                 cmd_valid_q, cmd_valid_d;
  cmd_enc_t             cmd_code_q, cmd_code_d;
  logic [BG_WIDTH-1:0]  cmd_bg_q, cmd_bg_d;
  logic [BA_WIDTH-1:0]  cmd_ba_q, cmd_ba_d;
  logic [ROW_WIDTH-1:0] cmd_row_q, cmd_row_d;
  logic [COL_WIDTH-1:0] cmd_col_q, cmd_col_d;
  logic                 illegal_q, illegal_d;
  logic                 parity_err_q, parity_err_d;
  logic [CL-1:0]        rd_sr_q, rd_sr_d;
  logic [CWL-1:0]       wr_sr_q, wr_sr_d;
  logic                 rd_launch_q, rd_launch_d;
  logic                 wr_capture_q, wr_capture_d;

  // Reset release synchronizer: run_s rises two edges after reset_n does.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  // Reset synchronizer flops.
  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign run_s = rst_sync_q[1];

  // Pin decode. ras/cas/we are taken at pin level, so 3'b111 is NOP.
  always_comb begin
    dec_code_s = DES;
    if (!bus.cke || bus.cs_n) begin
      dec_code_s = DES;
    end else if (!bus.act_n) begin
      dec_code_s = ACT;
    end else begin
      case ({bus.ras_n_a16, bus.cas_n_a15, bus.we_n_a14})
        3'b010:  dec_code_s = bus.ap_a10 ? PREA : PRE;
        3'b101:  dec_code_s = CAS_R;
        3'b100:  dec_code_s = CAS_W;
        3'b000:  dec_code_s = MRS;
        3'b001:  dec_code_s = REF;
        3'b110:  dec_code_s = ZQCL;
        3'b111:  dec_code_s = NOP;
        default: dec_code_s = RSVD;
      endcase
    end
    row_s = {bus.we_n_a14, bus.addr13, bus.bc_n_a12, bus.addr11,
             bus.ap_a10, bus.addr9_0};
`ifdef DDR_CMD_PARITY_EN
    par_err_s = bus.cke && !bus.cs_n &&
                parity_odd({bus.act_n, bus.ras_n_a16, bus.cas_n_a15,
                            bus.we_n_a14, bus.addr17, bus.addr13,
                            bus.bc_n_a12, bus.addr11, bus.ap_a10,
                            bus.addr9_0, bus.bg_addr, bus.ba_addr, bus.PAR});
`else
    par_err_s = 1'b0;
`endif
    // A parity failure demotes the command to NOP so nothing downstream acts.
    code_s = par_err_s ? NOP : dec_code_s;
    go_s   = (code_s != DES) && (code_s != NOP);
  end

  ddr_bank_tracker u_bank_tracker (
    .clock_t     (clock_t),
    .reset_n     (reset_n),
    .run_i       (run_s),
    .cmd_go_i    (go_s),
    .cmd_code_i  (code_s),
    .bg_i        (bus.bg_addr),
    .ba_i        (bus.ba_addr),
    .row_i       (row_s),
    .illegal_o   (illegal_s),
    .bank_open_o (bus.bank_open),
    .open_row_o  (open_row_s)
  );

  // Open rows are kept for the memory model; PAR/addr17 only feed parity.
  assign unused_s = ^{bus.PAR, bus.addr17, open_row_s};

  // Output registers and CL/CWL latency pipelines.
  always_comb begin
    cmd_valid_d  = go_s;
    cmd_code_d   = code_s;
    illegal_d    = illegal_s;
    parity_err_d = par_err_s;
    cmd_bg_d     = cmd_bg_q;
    cmd_ba_d     = cmd_ba_q;
    cmd_row_d    = cmd_row_q;
    cmd_col_d    = cmd_col_q;
    rd_sr_d      = {rd_sr_q[CL-2:0],  go_s && !illegal_s && (code_s == CAS_R)};
    wr_sr_d      = {wr_sr_q[CWL-2:0], go_s && !illegal_s && (code_s == CAS_W)};
    rd_launch_d  = rd_sr_q[CL-1];
    wr_capture_d = wr_sr_q[CWL-1];
    if (go_s) begin
      cmd_bg_d = bus.bg_addr;
      cmd_ba_d = bus.ba_addr;
      if ((code_s == ACT) || (code_s == MRS)) begin
        cmd_row_d = row_s;
      end else begin
        cmd_row_d = cmd_row_q;
      end
      if ((code_s == CAS_R) || (code_s == CAS_W)) begin
        cmd_col_d = bus.addr9_0;
      end else begin
        cmd_col_d = cmd_col_q;
      end
    end else begin
      cmd_bg_d = cmd_bg_q;
    end
    // Hold everything at reset values until the synchronizer releases.
    if (!run_s) begin
      cmd_valid_d  = 1'b0;
      cmd_code_d   = NOP;
      illegal_d    = 1'b0;
      parity_err_d = 1'b0;
      cmd_bg_d     = '0;
      cmd_ba_d     = '0;
      cmd_row_d    = '0;
      cmd_col_d    = '0;
      rd_sr_d      = '0;
      wr_sr_d      = '0;
      rd_launch_d  = 1'b0;
      wr_capture_d = 1'b0;
    end else begin
      cmd_valid_d = cmd_valid_d;
    end
  end

  // Registered outputs and latency shift registers.
  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) begin
      cmd_valid_q  <= 1'b0;
      cmd_code_q   <= NOP;
      illegal_q    <= 1'b0;
      parity_err_q <= 1'b0;
      cmd_bg_q     <= '0;
      cmd_ba_q     <= '0;
      cmd_row_q    <= '0;
      cmd_col_q    <= '0;
      rd_sr_q      <= '0;
      wr_sr_q      <= '0;
      rd_launch_q  <= 1'b0;
      wr_capture_q <= 1'b0;
    end else begin
      cmd_valid_q  <= cmd_valid_d;
      cmd_code_q   <= cmd_code_d;
      illegal_q    <= illegal_d;
      parity_err_q <= parity_err_d;
      cmd_bg_q     <= cmd_bg_d;
      cmd_ba_q     <= cmd_ba_d;
      cmd_row_q    <= cmd_row_d;
      cmd_col_q    <= cmd_col_d;
      rd_sr_q      <= rd_sr_d;
      wr_sr_q      <= wr_sr_d;
      rd_launch_q  <= rd_launch_d;
      wr_capture_q <= wr_capture_d;
    end
  end

  assign bus.cmd_valid  = cmd_valid_q;
  assign bus.cmd_code   = cmd_code_q;
  assign bus.cmd_bg     = cmd_bg_q;
  assign bus.cmd_ba     = cmd_ba_q;
  assign bus.cmd_row    = cmd_row_q;
  assign bus.cmd_col    = cmd_col_q;
  assign bus.illegal    = illegal_q;
  assign bus.parity_err = parity_err_q;
  assign bus.rd_launch  = rd_launch_q;
  assign bus.wr_capture = wr_capture_q;

endmodule
